// File: rtl/sync_fifo_drain.sv
// Receive-side circular buffer behind the CDC synchroniser: accepts every strobe,
// presents words as a valid/ready stream, and reports words dropped while full.
module sync_fifo_drain #(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full = (count == LW'(DEPTH));
    assign pop  = (count != '0) && out_ready;
    // A pop frees the head slot this cycle, so a full buffer can still accept.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Storage has no reset; writes are blocked during reset so the reset-cycle strobe is ignored.
    always_ff @(posedge clk_sys) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end

            // A drop in the same cycle as a clear wins and restarts the count at 1.
            if (drop) begin
                overflow <= 1'b1;
                if (overflow_clr) begin
                    drop_count <= 8'd1;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (overflow_clr) begin
                overflow   <= 1'b0;
                drop_count <= 8'd0;
            end
        end
    end

    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign level       = count;
    assign almost_full = (count >= LW'(AFULL_LEVEL));

endmodule
